nn_layer_sequencer: RTL and testbench
=====================================

# nn_layer_sequencer

Top-level sequencer for the digit-recognition inference pipeline. Launches the network layers in order: a settle window, then a one-cycle go pulse to the active layer, then a wait for that layer's done, then advance. Generalizes two-stage go/done sequencing to NUM_LAYERS stages, adding restart-on-start, abort and an optional watchdog. Sits between the host/input-capture logic and the per-layer compute engines.

## Interface
- NUM_LAYERS, 2: number of sequenced layers, 2..8.
- IDX_W, 3: width of layer_idx, at least clog2(NUM_LAYERS).
- PRE_WAIT, 2: settle cycles before go of layer 0, at least 1.
- TIMEOUT_CYCLES, 65535: watchdog limit in WAIT_DONE; used only with NN_SEQ_TIMEOUT_EN.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state and outputs clear immediately on assertion.
- start  in  1  request inference; sampled every cycle.
- abort  in  1  synchronous cancel of the current run.
- done_in  in  NUM_LAYERS  per-layer completion; bit i honoured only while layer i is active in WAIT_DONE.
- go  out  NUM_LAYERS  one-hot, one-cycle launch pulse to layer i.
- layer_idx  out  IDX_W  active layer index.
- busy  out  1  high whenever state is not IDLE.
- result_valid  out  1  one-cycle pulse: final layer completed.
- timeout_err  out  1  one-cycle pulse: watchdog expired.

## Operation
- States: IDLE, SETTLE, GO, WAIT_DONE, FINISH.
- Outputs are decoded from registered state and counters only (Moore); no input-to-output combinational path.
- Reset values: state IDLE, go 0, layer_idx 0, busy 0, result_valid 0, timeout_err 0, pending restart 0, counters 0.
- IDLE: start=1 goes to SETTLE with layer_idx=0 and settle counter=0.
- SETTLE: counts PRE_WAIT cycles, then GO.
- GO: exactly one cycle with go[layer_idx]=1, then WAIT_DONE.
- WAIT_DONE: waits for done_in[layer_idx]; other done_in bits are ignored. On done:
  - pending restart set: clear it, layer_idx=0, go to SETTLE.
  - otherwise, if layer_idx < NUM_LAYERS-1: layer_idx+1, go to GO directly (no settle).
  - otherwise: FINISH.
- FINISH: one cycle with result_valid=1, then IDLE; layer_idx returns to 0.
- Pending restart: start=1 in any non-IDLE state other than FINISH sets a sticky flag. start in FINISH is dropped; FINISH still returns to IDLE.
- abort=1 in any non-IDLE state: IDLE next cycle, pending cleared, no result_valid, no go. abort has priority over done_in and start in the same cycle. In IDLE with start=1 and abort=1, stay IDLE.

## Timing
- start high at edge k from IDLE: SETTLE for cycles k+1..k+PRE_WAIT; go[0] high in cycle k+PRE_WAIT+1.
- done_in[i] sampled at edge m in WAIT_DONE (not last layer): go[i+1] high in cycle m+1.
- done_in of the last layer at edge m: result_valid high in cycle m+1; busy low from cycle m+2.
- done_in asserted during the GO cycle is ignored; the layer must hold or re-assert it in WAIT_DONE.
- Reset asserted mid-run: outputs clear asynchronously. After deassertion the block is IDLE and ignores done_in until a new start.

## Configuration
- NN_SEQ_TIMEOUT_EN defined: a watchdog counter clears on entry to WAIT_DONE and increments each cycle there. When the count reaches TIMEOUT_CYCLES without done, timeout_err pulses one cycle, state goes to IDLE, and pending restart clears. Abort takes precedence over timeout in the same cycle.
- NN_SEQ_TIMEOUT_EN undefined: no watchdog logic; timeout_err is tied 0; WAIT_DONE waits indefinitely.

## Test plan
- NUM_LAYERS=2, PRE_WAIT=2; start pulse at cycle 0; done_in[0] 5 cycles after go[0]; done_in[1] 3 cycles after go[1] -> go[0] at cycle 3, go[1] one cycle after done_in[0], result_valid one cycle after done_in[1], busy low the following cycle.
- start pulsed while layer 0 is in WAIT_DONE -> on done_in[0], layer_idx=0, a new PRE_WAIT settle, go[0] again, go[1] never issued for the first run, exactly one result_valid in total.
- abort together with done_in[0] -> IDLE next cycle, no go[1], no result_valid; a later start runs normally.
- done_in[1] held high throughout and done_in[0] asserted during the GO cycle only -> neither is honoured; block stays in WAIT_DONE for layer 0.
- NN_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=10, done never asserted -> timeout_err pulses 10 cycles after entering WAIT_DONE, then busy=0. Without the macro -> timeout_err stays 0 and busy stays 1.
- Reset driven low during WAIT_DONE of layer 1 -> go, busy and layer_idx go 0 without a clock edge; after release, a late done_in[1] produces no result_valid.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// Layer launch sequencer: settle, one-cycle go per layer, wait for done, advance; restart/abort aware.
// Optional watchdog in WAIT_DONE is compiled in with NN_SEQ_TIMEOUT_EN.
module nn_layer_sequencer #(
    parameter int unsigned NUM_LAYERS     = 2,
    parameter int unsigned IDX_W          = 3,
    parameter int unsigned PRE_WAIT       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] done_in,
    output logic [NUM_LAYERS-1:0] go,
    output logic [IDX_W-1:0]      layer_idx,
    output logic                  busy,
    output logic                  result_valid,
    output logic                  timeout_err
);

    localparam int unsigned SET_W = (PRE_WAIT > 1) ? $clog2(PRE_WAIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        GO,
        WAIT_DONE,
        FINISH
    } state_t;

    if (NUM_LAYERS < 2 || NUM_LAYERS > 8 || PRE_WAIT < 1 || TIMEOUT_CYCLES < 1
        || (2 ** IDX_W) < NUM_LAYERS) begin : g_param_err
        $error("nn_layer_sequencer: illegal parameter combination");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             pend_q, pend_d;
    logic             done_sel;

`ifdef NN_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            tmo_q, tmo_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            pend_q   <= 1'b0;
`ifdef NN_SEQ_TIMEOUT_EN
            wd_q     <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            pend_q   <= pend_d;
`ifdef NN_SEQ_TIMEOUT_EN
            wd_q     <= wd_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Only the active layer's done bit is observed.
    always_comb begin
        done_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (idx_q == IDX_W'(i)) done_sel = done_in[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        pend_d   = pend_q;
`ifdef NN_SEQ_TIMEOUT_EN
        wd_d     = wd_q;
        tmo_d    = 1'b0;
`endif
        if (start && (state_q == SETTLE || state_q == GO || state_q == WAIT_DONE)) pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = SETTLE;
                    idx_d    = '0;
                    settle_d = '0;
                    pend_d   = 1'b0;
                end
            end
            SETTLE: begin
                if (settle_q == SET_W'(PRE_WAIT - 1)) state_d = GO;
                else settle_d = settle_q + 1'b1;
            end
            GO: begin
                state_d = WAIT_DONE;
`ifdef NN_SEQ_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            WAIT_DONE: begin
                if (done_sel) begin
                    // A start seen in the same cycle as done counts as a pending restart.
                    if (pend_q || start) begin
                        pend_d   = 1'b0;
                        idx_d    = '0;
                        settle_d = '0;
                        state_d  = SETTLE;
                    end else if (idx_q < IDX_W'(NUM_LAYERS - 1)) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = GO;
                    end else begin
                        state_d = FINISH;
                    end
                end
`ifdef NN_SEQ_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                    pend_d  = 1'b0;
                    idx_d   = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            FINISH: begin
                state_d = IDLE;
                idx_d   = '0;
                pend_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                pend_d  = 1'b0;
            end
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            idx_d   = '0;
            pend_d  = 1'b0;
`ifdef NN_SEQ_TIMEOUT_EN
            tmo_d   = 1'b0;
`endif
        end
    end

    always_comb begin
        go = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (state_q == GO && idx_q == IDX_W'(i)) go[i] = 1'b1;
        end
        layer_idx    = idx_q;
        busy         = (state_q != IDLE);
        result_valid = (state_q == FINISH);
`ifdef NN_SEQ_TIMEOUT_EN
        timeout_err  = tmo_q;
`else
        timeout_err  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: normal run, restart, abort, done masking, watchdog, async reset.
module tb_nn_layer_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [1:0] done_in;
    logic [1:0] go;
    logic [2:0] layer_idx;
    logic       busy;
    logic       result_valid;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;
    int rv_cnt = 0;
    int go1_cnt = 0;
    int te_cnt = 0;

    nn_layer_sequencer #(
        .NUM_LAYERS(2),
        .IDX_W(3),
        .PRE_WAIT(2),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .done_in(done_in),
        .go(go),
        .layer_idx(layer_idx),
        .busy(busy),
        .result_valid(result_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid) rv_cnt++;
        if (go[1]) go1_cnt++;
        if (timeout_err) te_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic full_run(input string tag);
        int rv0;
        rv0 = rv_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({tag, "_settle_busy"}, busy, 1);
        check_eq({tag, "_settle_go"}, go, 0);
        tick();
        check_eq({tag, "_settle2_go"}, go, 0);
        tick();
        check_eq({tag, "_go0"}, go, 2'b01);
        check_eq({tag, "_idx0"}, layer_idx, 0);
        repeat (4) tick();
        check_eq({tag, "_wait_go"}, go, 0);
        done_in = 2'b01;
        tick();
        done_in = 2'b00;
        check_eq({tag, "_go1"}, go, 2'b10);
        check_eq({tag, "_idx1"}, layer_idx, 1);
        tick();
        tick();
        done_in = 2'b10;
        tick();
        done_in = 2'b00;
        check_eq({tag, "_rv"}, result_valid, 1);
        check_eq({tag, "_fin_busy"}, busy, 1);
        tick();
        check_eq({tag, "_rv_off"}, result_valid, 0);
        check_eq({tag, "_idle_busy"}, busy, 0);
        check_eq({tag, "_idle_idx"}, layer_idx, 0);
        check_eq({tag, "_rv_count"}, rv_cnt - rv0, 1);
    endtask

    // Start from IDLE and stop in the first WAIT_DONE period of layer 0.
    task automatic to_wait0();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        int rv0;
        int go10;
        reset   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        done_in = 2'b00;
        tick();
        tick();
        check_eq("rst_go", go, 0);
        check_eq("rst_idx", layer_idx, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rv", result_valid, 0);
        check_eq("rst_te", timeout_err, 0);
        #2 reset = 1'b1;
        tick();
        check_eq("post_rst_busy", busy, 0);

        full_run("run1");

        // restart while layer 0 waits
        rv0  = rv_cnt;
        go10 = go1_cnt;
        to_wait0();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        done_in = 2'b01;
        tick();
        done_in = 2'b00;
        check_eq("rs_idx", layer_idx, 0);
        check_eq("rs_go", go, 0);
        check_eq("rs_busy", busy, 1);
        check_eq("rs_no_go1", go1_cnt - go10, 0);
        tick();
        check_eq("rs_settle2_go", go, 0);
        tick();
        check_eq("rs_go0", go, 2'b01);
        tick();
        done_in = 2'b01;
        tick();
        done_in = 2'b00;
        check_eq("rs_go1", go, 2'b10);
        tick();
        done_in = 2'b10;
        tick();
        done_in = 2'b00;
        check_eq("rs_rv", result_valid, 1);
        tick();
        check_eq("rs_rv_total", rv_cnt - rv0, 1);
        check_eq("rs_go1_total", go1_cnt - go10, 1);

        // abort together with done of layer 0
        rv0  = rv_cnt;
        go10 = go1_cnt;
        to_wait0();
        done_in = 2'b01;
        abort   = 1'b1;
        tick();
        done_in = 2'b00;
        abort   = 1'b0;
        check_eq("ab_busy", busy, 0);
        check_eq("ab_go", go, 0);
        tick();
        tick();
        check_eq("ab_no_rv", rv_cnt - rv0, 0);
        check_eq("ab_no_go1", go1_cnt - go10, 0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("ab_idle_start", busy, 0);
        full_run("run2");

        // done during GO only, and a foreign done bit held high
        rv0 = rv_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_eq("mask_go0", go, 2'b01);
        done_in = 2'b11;
        tick();
        done_in = 2'b10;
        repeat (3) tick();
        check_eq("mask_busy", busy, 1);
        check_eq("mask_idx", layer_idx, 0);
        check_eq("mask_go", go, 0);
        check_eq("mask_rv", rv_cnt - rv0, 0);
        done_in = 2'b00;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("mask_abort_busy", busy, 0);

        // watchdog
        to_wait0();
`ifdef NN_SEQ_TIMEOUT_EN
        repeat (9) tick();
        check_eq("wd_pre_te", timeout_err, 0);
        check_eq("wd_pre_busy", busy, 1);
        tick();
        check_eq("wd_te", timeout_err, 1);
        check_eq("wd_busy", busy, 0);
        tick();
        check_eq("wd_te_off", timeout_err, 0);
        check_eq("wd_te_count", te_cnt, 1);
`else
        repeat (30) tick();
        check_eq("nowd_busy", busy, 1);
        check_eq("nowd_te_count", te_cnt, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("nowd_abort_busy", busy, 0);
`endif

        // async reset during WAIT_DONE of layer 1
        rv0 = rv_cnt;
        to_wait0();
        done_in = 2'b01;
        tick();
        done_in = 2'b00;
        check_eq("ar_go1", go, 2'b10);
        tick();
        check_eq("ar_pre_idx", layer_idx, 1);
        #2 reset = 1'b0;
        #1;
        check_eq("ar_go", go, 0);
        check_eq("ar_busy", busy, 0);
        check_eq("ar_idx", layer_idx, 0);
        tick();
        #2 reset = 1'b1;
        done_in = 2'b10;
        repeat (3) tick();
        done_in = 2'b00;
        check_eq("ar_late_rv", rv_cnt - rv0, 0);
        check_eq("ar_late_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
